div_unit: RTL and testbench

Iterative 32-bit integer divider for the MIPS datapath; executes DIV/DIVU by restoring shift-and-subtract, one quotient bit per clock. It is the inverse of the adder: each step is a 33-bit subtract whose borrow decides the quotient bit. It sits beside the ALU and feeds the HI (remainder) and LO (quotient) registers; the control unit stalls the pipeline while `Busy` is high.

---
 rtl/mips_pkg.sv | 15 +
 rtl/div_unit_if.sv | 26 ++
 rtl/div_step.sv | 19 +
 rtl/div_unit.sv | 171 +++++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the iterative divider.
package mips_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the control unit and the divider.
interface div_unit_if
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivByZero;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, Quotient, Remainder, DivByZero
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, Quotient, Remainder, DivByZero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder; the inverted borrow is the quotient bit.
module div_step
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             qbit
);
    logic [WIDTH:0] diff;

    // partial < 2*divisor, so the WIDTH+1-bit sign bit is an exact borrow
    assign diff     = partial - {1'b0, divisor};
    assign qbit     = ~diff[WIDTH];
    assign next_rem = qbit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per clock.
// Define DIV_SIGNED_EN to honour Signed; otherwise every division is unsigned.
module div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic       Clk,
    input logic       Reset_n,
    div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] fix_quo, fix_rem;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    // busy_q is still high in IDLE during the Done cycle, which blocks a Start there
    assign accept = (state_q == IDLE) && bus.Start && !busy_q;

`ifdef DIV_SIGNED_EN
    logic sgn;
    logic neg_quo_q, neg_rem_q;

    assign sgn   = bus.Signed;
    assign abs_a = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Capture result signs alongside the operands
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            neg_quo_q <= sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_rem_q <= sgn && bus.A[WIDTH-1];
        end
    end

    assign fix_quo = neg_quo_q ? -quo_q : quo_q;
    assign fix_rem = neg_rem_q ? -rem_q : rem_q;
`else
    logic unused_signed;

    assign unused_signed = bus.Signed;
    assign abs_a   = bus.A;
    assign abs_b   = bus.B;
    assign fix_quo = quo_q;
    assign fix_rem = rem_q;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .partial (({rem_q, quo_q[WIDTH-1]})),
        .divisor (dvs_q),
        .next_rem(step_rem),
        .qbit    (step_bit)
    );

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state, shift/subtract datapath and result registration
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (accept) begin
                    busy_d  = 1'b1;
                    a_d     = bus.A;
                    zero_d  = (bus.B == '0);
                    rem_d   = '0;
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    cnt_d   = CntW'(WIDTH - 1);
                    state_d = (bus.B == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (zero_q) begin
                    q_out_d = DIV_ZERO_QUOTIENT[WIDTH-1:0];
                    r_out_d = a_q;
                    dbz_d   = 1'b1;
                end else begin
                    q_out_d = fix_quo;
                    r_out_d = fix_rem;
                    dbz_d   = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Quotient  = q_out_q;
    assign bus.Remainder = r_out_q;
    assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;
    import mips_pkg::*;

    localparam int unsigned W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 Clk = ~Clk;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(
        .WIDTH(W)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Division as the ISA defines it, from plain integer arithmetic
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        int sa, sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (!(s && SignedEn)) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, output logic [31:0] oq, output logic [31:0] orem);
        logic [31:0] eq, er;
        logic        ez;
        int          lat;
        model(a, b, s, eq, er, ez);
        @(negedge Clk);
        bus.Start  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.Signed = s;
        @(posedge Clk);
        #1;
        bus.Start  = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
        bus.Signed = 1'($urandom);
        check({tag, "_busy_rise"}, 32'(bus.Busy), 32'd1);
        lat = 0;
        while (!bus.Done && lat < 100) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), (b == 32'd0) ? 32'd2 : 32'd34);
        check({tag, "_quo"}, bus.Quotient, eq);
        check({tag, "_rem"}, bus.Remainder, er);
        check({tag, "_dbz"}, 32'(bus.DivByZero), 32'(ez));
        check({tag, "_busy_done"}, 32'(bus.Busy), 32'd1);
        oq   = bus.Quotient;
        orem = bus.Remainder;
        @(posedge Clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
        check({tag, "_busy_fall"}, 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] q, r, a, b;
        logic        s;
        int          n_done, lat;

        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;

        // Reset state
        #12;
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_quo", bus.Quotient, 32'd0);
        check("rst_rem", bus.Remainder, 32'd0);
        check("rst_dbz", 32'(bus.DivByZero), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Test plan vectors
        do_div("u100_7", 32'd100, 32'd7, 1'b0, q, r);
        check("u100_7_lit_q", q, 32'd14);
        check("u100_7_lit_r", r, 32'd2);
        do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
        do_div("zero", 32'h1234_5678, 32'd0, 1'b0, q, r);
        check("zero_lit_q", q, 32'hFFFF_FFFF);
        check("zero_lit_r", r, 32'h1234_5678);
        do_div("zero_s", 32'h8765_4321, 32'd0, 1'b1, q, r);
        check("zero_s_lit_r", r, 32'h8765_4321);
        do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
        do_div("s_neg_div", 32'd100, 32'hFFFF_FFF9, 1'b1, q, r);

        // Start during a running division is ignored
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        bus.Signed = 1'b0;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 32'd5;
        bus.B     = 32'd1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        lat = 0;
        while (!bus.Done && lat < 100) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check("ign_latency", 32'(lat), 32'd24);
        check("ign_quo", bus.Quotient, 32'd14);
        check("ign_rem", bus.Remainder, 32'd2);
        n_done = 0;
        repeat (50) begin
            @(posedge Clk);
            #1;
            if (bus.Done) n_done++;
        end
        check("ign_no_second_done", 32'(n_done), 32'd0);
        check("ign_idle_busy", 32'(bus.Busy), 32'd0);

        // Reset in the middle of a division
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 32'd1000;
        bus.B     = 32'd3;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (19) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("mrst_busy", 32'(bus.Busy), 32'd0);
        check("mrst_done", 32'(bus.Done), 32'd0);
        check("mrst_quo", bus.Quotient, 32'd0);
        check("mrst_rem", bus.Remainder, 32'd0);
        check("mrst_dbz", 32'(bus.DivByZero), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        do_div("post_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, q, r);
        check("post_rst_lit_q", q, 32'hFFFF_FFFF);
        check("post_rst_lit_r", r, 32'd0);

        // Random operands, biased towards small divisors, zero and -1
        for (int i = 0; i < 24; i++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            a   = (sel == 6) ? 32'h8000_0000 : $urandom;
            if (sel == 0)      b = 32'd0;
            else if (sel < 3)  b = $urandom_range(1, 15);
            else if (sel == 3) b = 32'hFFFF_FFFF;
            else               b = $urandom;
            s = 1'($urandom);
            do_div($sformatf("rnd%0d", i), a, b, s, q, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
